// File: rtl/fetch_pkg.sv
// Shared types and constants for the instruction fetch unit.
package fetch_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    FETCH = 2'd1,
    HOLD  = 2'd2,
    FAULT = 2'd3
  } state_e;

  typedef enum logic [1:0] {
    FC_NONE       = 2'b00,
    FC_MISALIGNED = 2'b01,
    FC_TIMEOUT    = 2'b10
  } fault_code_e;

  localparam logic [31:0] INSTR_BYTES = 32'd4;

  // Wide enough for any TIMEOUT in 1..255.
  localparam int TIMEOUT_W = 8;

endpackage

// File: rtl/fetch_watchdog.sv
// Wait counter for outstanding instruction-memory requests.
//   clear   : zero the counter (priority over enable)
//   enable  : count one more cycle without a response
//   expired : this is the TIMEOUT-th waiting cycle
module fetch_watchdog
  import fetch_pkg::*;
#(
  parameter int unsigned TIMEOUT = 16
) (
  input  logic clk,
  input  logic reset,
  input  logic clear,
  input  logic enable,
  output logic expired
);

  localparam logic [TIMEOUT_W-1:0] LAST = TIMEOUT_W'(TIMEOUT - 1);

  logic [TIMEOUT_W-1:0] count_q, count_d;

  always_comb begin
    count_d = count_q;
    if (clear) begin
      count_d = '0;
    end else if (enable) begin
      count_d = count_q + 1'b1;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      count_q <= '0;
    end else begin
      count_q <= count_d;
    end
  end

  // count_q holds the number of cycles already waited, so the cycle in which
  // it equals TIMEOUT-1 is the last one in which an ack is still accepted.
  assign expired = (count_q == LAST);

endmodule

// File: rtl/fetch_unit.sv
// Instruction fetch unit: requests one word at a time from instruction
// memory, holds it for the consumer, and follows jumps/taken branches.
//   clk, reset                   : clock, async active-high reset
//   imem_req/addr, ack/rdata     : instruction-memory read port
//   instr_valid/ready            : handshake to the datapath
//   instruction, pc              : held instruction and its address
//   jump, branch_taken, target   : redirect, sampled on accept only
//   fault, fault_code            : sticky fault and its cause
//   retired_count                : accepted instruction count
module fetch_unit
  import fetch_pkg::*;
#(
  parameter logic [31:0] RESET_PC = 32'h0000_0000,
  parameter int unsigned TIMEOUT  = 16
) (
  input  logic        clk,
  input  logic        reset,
  output logic        imem_req,
  output logic [31:0] imem_addr,
  input  logic        imem_ack,
  input  logic [31:0] imem_rdata,
  output logic        instr_valid,
  input  logic        instr_ready,
  output logic [31:0] instruction,
  output logic [31:0] pc,
  input  logic        jump,
  input  logic        branch_taken,
  input  logic [31:0] target_addr,
  output logic        fault,
  output logic [1:0]  fault_code,
  output logic [31:0] retired_count
);

  state_e      state_q, state_d;
  logic [31:0] pc_q, pc_d;
  logic [31:0] instr_q, instr_d;
  fault_code_e fcode_q, fcode_d;
  logic [31:0] retired_q, retired_d;

  logic wd_clear, wd_enable, wd_expired;

  fetch_watchdog #(
    .TIMEOUT (TIMEOUT)
  ) u_watchdog (
    .clk     (clk),
    .reset   (reset),
    .clear   (wd_clear),
    .enable  (wd_enable),
    .expired (wd_expired)
  );

  always_comb begin
    state_d   = state_q;
    pc_d      = pc_q;
    instr_d   = instr_q;
    fcode_d   = fcode_q;
    retired_d = retired_q;
    wd_clear  = 1'b0;
    wd_enable = 1'b0;

    case (state_q)
      IDLE: begin
        state_d  = FETCH;
        wd_clear = 1'b1;
      end
      FETCH: begin
        // An ack in the expiring cycle still wins over the timeout.
        if (imem_ack) begin
          instr_d = imem_rdata;
          state_d = HOLD;
        end else if (wd_expired) begin
          fcode_d = FC_TIMEOUT;
          state_d = FAULT;
        end else begin
          wd_enable = 1'b1;
        end
      end
      HOLD: begin
        if (instr_ready) begin
          retired_d = retired_q + 32'd1;
          if (jump || branch_taken) begin
            if (target_addr[1:0] == 2'b00) begin
              pc_d     = target_addr;
              state_d  = FETCH;
              wd_clear = 1'b1;
            end else begin
              // The instruction still retires; pc keeps its address.
              fcode_d = FC_MISALIGNED;
              state_d = FAULT;
            end
          end else begin
            pc_d     = pc_q + INSTR_BYTES;
            state_d  = FETCH;
            wd_clear = 1'b1;
          end
        end
      end
      FAULT: begin
        state_d = FAULT;
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q   <= IDLE;
      pc_q      <= RESET_PC;
      instr_q   <= '0;
      fcode_q   <= FC_NONE;
      retired_q <= '0;
    end else begin
      state_q   <= state_d;
      pc_q      <= pc_d;
      instr_q   <= instr_d;
      fcode_q   <= fcode_d;
      retired_q <= retired_d;
    end
  end

  assign imem_req      = (state_q == FETCH);
  assign imem_addr     = pc_q;
  assign instr_valid   = (state_q == HOLD);
  assign instruction   = instr_q;
  assign pc            = pc_q;
  assign fault         = (state_q == FAULT);
  assign fault_code    = fcode_q;
  assign retired_count = retired_q;

endmodule

// File: tb/tb_fetch_unit.sv
// Self-checking bench for fetch_unit (TIMEOUT overridden to 4).
module tb_fetch_unit;

  localparam logic [31:0] RST_PC = 32'h0000_0000;
  localparam int unsigned TB_TIMEOUT = 4;

  logic        clk = 1'b0;
  logic        reset = 1'b0;
  logic        imem_req;
  logic [31:0] imem_addr;
  logic        imem_ack = 1'b0;
  logic [31:0] imem_rdata = '0;
  logic        instr_valid;
  logic        instr_ready = 1'b0;
  logic [31:0] instruction;
  logic [31:0] pc;
  logic        jump = 1'b0;
  logic        branch_taken = 1'b0;
  logic [31:0] target_addr = '0;
  logic        fault;
  logic [1:0]  fault_code;
  logic [31:0] retired_count;

  int n_chk = 0;
  int n_bad = 0;

  // Memory responder knobs.
  bit          mem_on   = 1'b1;
  bit          mem_rand = 1'b0;
  bit          noise_en = 1'b0;
  bit          late_ack = 1'b0;
  int unsigned mem_lat  = 0;
  int unsigned wait_n   = 0;

  fetch_unit #(
    .RESET_PC (RST_PC),
    .TIMEOUT  (TB_TIMEOUT)
  ) u_dut (
    .clk           (clk),
    .reset         (reset),
    .imem_req      (imem_req),
    .imem_addr     (imem_addr),
    .imem_ack      (imem_ack),
    .imem_rdata    (imem_rdata),
    .instr_valid   (instr_valid),
    .instr_ready   (instr_ready),
    .instruction   (instruction),
    .pc            (pc),
    .jump          (jump),
    .branch_taken  (branch_taken),
    .target_addr   (target_addr),
    .fault         (fault),
    .fault_code    (fault_code),
    .retired_count (retired_count)
  );

  always #5 clk = ~clk;

  function automatic logic [31:0] memw(input logic [31:0] a);
    return (a * 32'h9E37_79B9) ^ 32'h5A5A_0F0F;
  endfunction

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s got=%h exp=%h t=%0t", tag, got, exp, $time);
    end
  endtask

  // Memory model: acks after mem_lat waiting cycles with a word derived
  // from the address; optionally emits stray acks when nothing is requested.
  always @(negedge clk) begin
    if (imem_req) begin
      if (mem_on && wait_n >= mem_lat) begin
        imem_ack   = 1'b1;
        imem_rdata = memw(imem_addr);
        wait_n     = 0;
        if (mem_rand) mem_lat = $urandom_range(0, TB_TIMEOUT - 1);
      end else begin
        imem_ack   = 1'b0;
        imem_rdata = $urandom;
        wait_n++;
      end
    end else begin
      imem_ack   = late_ack || (noise_en && ($urandom_range(0, 2) == 0));
      imem_rdata = $urandom;
      wait_n     = 0;
    end
  end

  task automatic chk_reset_vals(input string tag);
    chk({tag, "_req"},   {31'd0, imem_req},     32'd0);
    chk({tag, "_addr"},  imem_addr,             RST_PC);
    chk({tag, "_pc"},    pc,                    RST_PC);
    chk({tag, "_instr"}, instruction,           32'd0);
    chk({tag, "_valid"}, {31'd0, instr_valid},  32'd0);
    chk({tag, "_fault"}, {31'd0, fault},        32'd0);
    chk({tag, "_fcode"}, {30'd0, fault_code},   32'd0);
    chk({tag, "_ret"},   retired_count,         32'd0);
  endtask

  task automatic quiet_inputs();
    instr_ready  = 1'b0;
    jump         = 1'b0;
    branch_taken = 1'b0;
    target_addr  = '0;
  endtask

  task automatic do_reset();
    @(negedge clk);
    reset = 1'b1;
    quiet_inputs();
    #1;
    chk_reset_vals("rst");
    repeat (2) @(negedge clk);
    reset = 1'b0;
  endtask

  task automatic wait_valid(input string tag);
    for (int unsigned i = 0; i < 20; i++) begin
      @(negedge clk);
      if (instr_valid) break;
    end
    chk({tag, "_valid"}, {31'd0, instr_valid}, 32'd1);
  endtask

  // Accept the held instruction with the given redirect, then return at the
  // following negedge with inputs quiet.
  task automatic accept(input bit j, input bit b, input logic [31:0] t);
    instr_ready  = 1'b1;
    jump         = j;
    branch_taken = b;
    target_addr  = t;
    @(negedge clk);
    quiet_inputs();
  endtask

  task automatic run_random(input int unsigned n);
    logic [31:0] exp_pc;
    logic [31:0] exp_ret;
    logic [31:0] tmp;
    bit          rdy;
    exp_pc  = RST_PC;
    exp_ret = '0;
    for (int unsigned c = 0; c < n; c++) begin
      @(negedge clk);
      chk("r_live",  {31'd0, imem_req | instr_valid}, 32'd1);
      chk("r_both",  {31'd0, imem_req & instr_valid}, 32'd0);
      chk("r_fault", {31'd0, fault},                  32'd0);
      chk("r_ret",   retired_count,                   exp_ret);
      if (imem_req) chk("r_addr", imem_addr, exp_pc);
      rdy = ($urandom_range(0, 2) != 0);
      instr_ready = rdy;
      if (instr_valid) begin
        chk("r_pc",    pc,          exp_pc);
        chk("r_instr", instruction, memw(exp_pc));
      end
      if (instr_valid && rdy) begin
        exp_ret = exp_ret + 32'd1;
        if ($urandom_range(0, 3) == 0) begin
          tmp = $urandom;
          if ($urandom_range(0, 7) == 0) tmp = 32'hFFFF_FFF8;
          tmp[1:0]     = 2'b00;
          target_addr  = tmp;
          jump         = $urandom_range(0, 1) != 0;
          branch_taken = !jump || ($urandom_range(0, 1) != 0);
          exp_pc       = tmp;
        end else begin
          jump         = 1'b0;
          branch_taken = 1'b0;
          target_addr  = $urandom;
          exp_pc       = exp_pc + 32'd4;
        end
      end else begin
        // Redirect inputs are garbage (often misaligned) outside accepts.
        jump         = $urandom_range(0, 1) != 0;
        branch_taken = $urandom_range(0, 1) != 0;
        target_addr  = $urandom;
      end
    end
    @(negedge clk);
    quiet_inputs();
    chk("r_ret_end", retired_count, exp_ret);
  endtask

  logic [31:0] addr_q [$];

  initial begin
    // Reset takes effect before any clock edge.
    #2 reset = 1'b1;
    #1 chk_reset_vals("rst0");

    // Zero-wait streaming: addresses 0,4,8,12 and 3 retired within 7 cycles.
    mem_on = 1'b1; mem_rand = 1'b0; mem_lat = 0; noise_en = 1'b0;
    do_reset();
    instr_ready = 1'b1;
    for (int unsigned c = 0; c < 7; c++) begin
      @(negedge clk);
      if (imem_req) addr_q.push_back(imem_addr);
    end
    chk("seq_n",   addr_q.size(), 32'd4);
    if (addr_q.size() == 4) begin
      chk("seq_a0", addr_q[0], 32'd0);
      chk("seq_a1", addr_q[1], 32'd4);
      chk("seq_a2", addr_q[2], 32'd8);
      chk("seq_a3", addr_q[3], 32'd12);
    end
    chk("seq_ret", retired_count, 32'd3);
    quiet_inputs();

    // Stall in HOLD for 5 cycles, with stray acks and redirect noise.
    do_reset();
    noise_en = 1'b1;
    wait_valid("stall");
    for (int unsigned c = 0; c < 5; c++) begin
      jump = 1'b1; target_addr = 32'h0000_0203;
      @(negedge clk);
      chk("stall_req",   {31'd0, imem_req},    32'd0);
      chk("stall_valid", {31'd0, instr_valid}, 32'd1);
      chk("stall_pc",    pc,                   32'd0);
      chk("stall_instr", instruction,          memw(32'd0));
      chk("stall_ret",   retired_count,        32'd0);
    end
    quiet_inputs();
    noise_en = 1'b0;

    // Jump and branch together to 0x100, then wrap from 0xFFFF_FFFC to 0.
    accept(1'b1, 1'b1, 32'h0000_0100);
    chk("jmp_addr", imem_addr, 32'h0000_0100);
    chk("jmp_ret",  retired_count, 32'd1);
    wait_valid("jmp");
    chk("jmp_pc",    pc,          32'h0000_0100);
    chk("jmp_instr", instruction, memw(32'h0000_0100));
    accept(1'b1, 1'b0, 32'hFFFF_FFFC);
    chk("wrap_addr0", imem_addr, 32'hFFFF_FFFC);
    wait_valid("wrap");
    accept(1'b0, 1'b0, 32'h0000_0002);
    chk("wrap_addr1", imem_addr, 32'd0);
    chk("wrap_ret",   retired_count, 32'd3);

    // Misaligned taken branch: retires, faults, pc stays, no more requests.
    wait_valid("mis");
    accept(1'b0, 1'b1, 32'h0000_0102);
    chk("mis_fault", {31'd0, fault},       32'd1);
    chk("mis_code",  {30'd0, fault_code},  32'd1);
    chk("mis_pc",    pc,                   32'd0);
    chk("mis_ret",   retired_count,        32'd4);
    noise_en = 1'b1;
    for (int unsigned c = 0; c < 6; c++) begin
      instr_ready = 1'b1; jump = 1'b1; target_addr = 32'h0000_0040;
      @(negedge clk);
      chk("mis_req",   {31'd0, imem_req},    32'd0);
      chk("mis_valid", {31'd0, instr_valid}, 32'd0);
      chk("mis_stick", {31'd0, fault},       32'd1);
      chk("mis_ret2",  retired_count,        32'd4);
    end
    noise_en = 1'b0;
    quiet_inputs();

    // No ack: timeout fault after exactly 4 FETCH cycles.
    mem_on = 1'b0;
    do_reset();
    for (int unsigned c = 0; c < 4; c++) begin
      @(negedge clk);
      chk("to_req",   {31'd0, imem_req}, 32'd1);
      chk("to_nflt",  {31'd0, fault},    32'd0);
    end
    @(negedge clk);
    chk("to_fault", {31'd0, fault},      32'd1);
    chk("to_code",  {30'd0, fault_code}, 32'd2);
    chk("to_req0",  {31'd0, imem_req},   32'd0);

    // Ack in the 4th FETCH cycle wins over the timeout.
    mem_on = 1'b1; mem_lat = 3;
    do_reset();
    for (int unsigned c = 0; c < 4; c++) begin
      @(negedge clk);
      chk("ack4_req", {31'd0, imem_req}, 32'd1);
    end
    @(negedge clk);
    chk("ack4_valid", {31'd0, instr_valid}, 32'd1);
    chk("ack4_fault", {31'd0, fault},       32'd0);
    chk("ack4_instr", instruction,          memw(32'd0));

    // Reset during a 3-cycle-latency fetch, with a late ack after release.
    instr_ready = 1'b1;
    for (int unsigned c = 0; c < 40; c++) begin
      @(negedge clk);
      if (imem_req && imem_addr == 32'd8) break;
    end
    chk("rf_addr", imem_addr, 32'd8);
    @(negedge clk);
    reset = 1'b1;
    quiet_inputs();
    #1;
    chk_reset_vals("rf");
    late_ack = 1'b1;
    @(negedge clk);
    @(negedge clk);
    reset = 1'b0;
    @(negedge clk);
    late_ack = 1'b0;
    chk("rf_req",   {31'd0, imem_req},    32'd1);
    chk("rf_addr0", imem_addr,            RST_PC);
    chk("rf_nval",  {31'd0, instr_valid}, 32'd0);
    wait_valid("rf");
    chk("rf_pc",    pc,                   RST_PC);
    chk("rf_instr", instruction,          memw(RST_PC));

    // Randomized traffic against the scoreboard.
    mem_rand = 1'b1; mem_lat = 1; noise_en = 1'b1;
    do_reset();
    run_random(3000);

    $display("test done: total=%0d bad=%0d", n_chk, n_bad);
    $finish;
  end

  // Absolute time limit so a hung bench still reports.
  initial begin
    #500000;
    $display("FAIL timeout total=%0d bad=%0d", n_chk, n_bad);
    $fatal(1, "time limit");
  end

endmodule
